gmii_rx_framer: RTL and testbench
=================================

# gmii_rx_framer

Receive-side front end of the Ethernet path: takes the raw 8-bit GMII byte stream from the PHY and strips preamble/SFD. It checks the FCS (CRC-32) and packs frame bytes MSB-first into 48-bit words. Words are delivered over a valid/ready handshake into the Ethernet layer's `mac_rx_data`/`mac_rx_valid`/`mac_rx_ready` input. GMII cannot be back-pressured, so the block owns an internal word FIFO and a per-frame status/drop path.

## Interface
- `FIFO_DEPTH`, 16: word FIFO entries (power of 2, ≥4).
- `MIN_FRAME`, 64: minimum good frame length in bytes, FCS included.
- `clk` in 1: single clock, GMII RX domain already synchronised upstream.
- `rst_n` in 1: reset, asynchronous, active-low.
- `gmii_rxd` in 8: received byte.
- `gmii_rx_dv` in 1: byte valid / frame envelope.
- `gmii_rx_er` in 1: PHY error on this byte.
- `mac_rx_data` out 48: packed word; first byte of frame in [47:40].
- `mac_rx_valid` out 1: word available.
- `mac_rx_ready` in 1: consumer accepts word.
- `mac_rx_last` out 1: word is final word of frame.
- `mac_rx_bytes` out 3: valid bytes in word (1..6); always 6 unless last.
- `mac_rx_err` out 1: valid only with last; frame bad.
- `frame_status_valid` out 1: one-cycle pulse at frame end.
- `frame_good` out 1: qualified by `frame_status_valid`.
- `drop_count` out 16: saturating count of bad/truncated frames.

## Operation
- FSM states IDLE, PREAMBLE, DATA, DROP. Reset → IDLE.
- IDLE: `rx_dv`=1 and byte 0x55 → PREAMBLE; any other byte with `rx_dv`=1 → DROP.
- PREAMBLE: 0x55 stays; 0xD5 → DATA (CRC seeded 0xFFFFFFFF, byte count 0); any other byte, or `rx_dv`=0 → IDLE. No FIFO writes.
- DATA: each byte updates the reflected CRC-32 (poly 0x04C11DB7) and shifts into the accumulator at the next lower byte lane. Byte count increments, saturating at 2047. The FCS bytes are forwarded; downstream strips them.
- A completed 6-byte word is held in a pending register and written to the FIFO when the next DATA byte arrives (last=0, bytes=6). Holding it lets the final word carry `last`.
- `rx_dv` falls in DATA: write the final word. Use the partial accumulator if it holds 1..5 bytes, otherwise the pending word. Set last=1 and bytes accordingly. Pulse status, return to IDLE.
- `err` = CRC residue ≠ 0xC704DD7B, or any `rx_er` in the frame, or count < `MIN_FRAME`, or overflow. `frame_good` = !err. A bad frame increments `drop_count` (saturates at 0xFFFF).
- FIFO reserves one entry. Normal writes require occupancy < `FIFO_DEPTH`-1. If a normal write would be refused: write the pending word into the reserved slot with last=1, err=1, mark overflow, and go to DROP.
- DROP: ignore bytes until `rx_dv`=0, then → IDLE. For an overflow-initiated drop, pulse status with good=0 at that point.
- Downstream therefore always sees a terminated frame.
- `rx_dv` reasserted on the cycle after deassert: treated as a new frame in IDLE.

## Timing
- Reset values: `mac_rx_valid`=0, `mac_rx_data`=0, `mac_rx_last`=0, `mac_rx_bytes`=0, `mac_rx_err`=0, `frame_status_valid`=0, `frame_good`=0, `drop_count`=0. FIFO empty, FSM IDLE.
- FIFO is first-word-fall-through. A word written on cycle N shows `mac_rx_valid`=1 on cycle N+1.
- Transfer occurs when valid && ready. Data and flags stay stable while valid && !ready.
- FIFO read and write in the same cycle is allowed at any occupancy, including full-minus-one.
- `frame_status_valid` pulses on the cycle after the `rx_dv` falling edge, which is the same cycle the last word is written. It is not flow-controlled.
- Reset mid-frame: FIFO flushed, no status pulse. The post-reset frame restarts in IDLE; a frame already in progress is dropped via IDLE→DROP.

## Structure
- Shared package `hft_eth_pkg`: constants PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC32_POLY, CRC32_INIT, CRC32_RESIDUE 0xC704DD7B; the FSM state enum; and the word-entry struct {data[47:0], last, bytes[2:0], err}.
- One sub-module, `eth_rx_word_fifo`: parameterised FWFT synchronous FIFO exposing occupancy. CRC-32 byte update is a package function, not a module.

## Test plan
- 7×0x55, 0xD5, 64-byte frame with valid FCS, ready=1 → 11 words (10×6 bytes, last with bytes=4); `frame_good`=1; `drop_count`=0.
- Same frame with byte 20 flipped → last word err=1; `frame_good`=0; `drop_count`=1.
- 60-byte frame with correct FCS → err=1 (runt); 10 words, last bytes=6.
- `gmii_rx_er` pulsed on byte 30 of a good 64-byte frame → err=1; data stream otherwise intact.
- ready=0 throughout a 200-byte frame, `FIFO_DEPTH`=16 → exactly 16 entries, the 16th with last=1 and err=1; remaining bytes dropped; one status pulse with good=0.
- Reset asserted at byte 40 of a frame, released, then a good frame → no valid from the aborted frame; second frame delivered with `frame_good`=1.

Source files
------------

// File: rtl/hft_eth_pkg.sv
// Shared Ethernet receive definitions: framing constants, FSM states, FIFO word
// layout and the byte-wise reflected CRC-32 update.
package hft_eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic [47:0] data;
        logic        last;
        logic [2:0]  bytes;
        logic        err;
    } rx_word_t;

    localparam int RX_WORD_W = $bits(rx_word_t);

    function automatic logic [31:0] bit_reverse32(input logic [31:0] value);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            result[i] = value[31-i];
        end
        return result;
    endfunction

    // LSB-first CRC-32 as used on the wire: one byte per call, no final inversion.
    function automatic logic [31:0] crc32_update(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic [31:0] poly_reflected;
        poly_reflected = bit_reverse32(CRC32_POLY);
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ poly_reflected) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_word_fifo.sv
// First-word-fall-through synchronous word FIFO with an occupancy output.
// A push is accepted when full only if a pop happens in the same cycle.
module eth_rx_word_fifo
    import hft_eth_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [RX_WORD_W-1:0]   push_word,
    input  logic                   pop,
    output logic [RX_WORD_W-1:0]   head_word,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [RX_WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [AW:0]          count_reg;
    logic                 do_push;
    logic                 do_pop;

    assign empty     = (count_reg == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && ((count_reg != FULL_COUNT) || do_pop);
    assign head_word = mem[rd_ptr_reg];
    assign count     = count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_word;
        end
    end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks FCS, packs bytes MSB-first
// into 48-bit words and queues them with per-frame status and overflow drop.
module gmii_rx_framer
    import hft_eth_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MIN_FRAME  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [47:0] mac_rx_data,
    output logic        mac_rx_valid,
    input  logic        mac_rx_ready,
    output logic        mac_rx_last,
    output logic [2:0]  mac_rx_bytes,
    output logic        mac_rx_err,
    output logic        frame_status_valid,
    output logic        frame_good,
    output logic [15:0] drop_count
);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [10:0] COUNT_MAX = 11'd2047;

    rx_state_t   state_reg, state_next;
    logic [31:0] crc_reg, crc_next;
    logic [10:0] count_reg, count_next;
    logic [47:0] acc_reg, acc_next;
    logic [2:0]  acc_cnt_reg, acc_cnt_next;
    logic [47:0] pend_reg, pend_next;
    logic        pend_valid_reg, pend_valid_next;
    logic        er_seen_reg, er_seen_next;
    logic        ovf_reg, ovf_next;
    logic        wr_en_reg, wr_en_next;
    rx_word_t    wr_entry_reg, wr_entry_next;
    logic        status_valid_reg, status_valid_next;
    logic        good_reg, good_next;
    logic [15:0] drop_count_reg, drop_count_next;

    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        occupancy;
    logic                 normal_room;
    logic                 reserve_room;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [RX_WORD_W-1:0] head_raw;
    rx_word_t             head;

    logic [47:0] lane_byte;
    logic        frame_err;
    logic        final_err;
    logic        has_word;
    logic [47:0] fin_data;
    logic [2:0]  fin_bytes;

    // The registered write lands one cycle later, so it already counts as occupied.
    assign occupancy    = fifo_count + CW'(wr_en_reg);
    assign normal_room  = occupancy < CW'(FIFO_DEPTH - 1);
    assign reserve_room = occupancy < CW'(FIFO_DEPTH);

    // The register holds the CRC bit-reflected, so reflect before the residue check.
    assign frame_err = (bit_reverse32(crc_reg) != CRC32_RESIDUE) || er_seen_reg
                       || (count_reg < 11'(MIN_FRAME));

    always_comb begin
        state_next        = state_reg;
        crc_next          = crc_reg;
        count_next        = count_reg;
        acc_next          = acc_reg;
        acc_cnt_next      = acc_cnt_reg;
        pend_next         = pend_reg;
        pend_valid_next   = pend_valid_reg;
        er_seen_next      = er_seen_reg;
        ovf_next          = ovf_reg;
        wr_en_next        = 1'b0;
        wr_entry_next     = wr_entry_reg;
        status_valid_next = 1'b0;
        good_next         = good_reg;
        drop_count_next   = drop_count_reg;
        lane_byte         = {gmii_rxd, 40'd0} >> {acc_cnt_reg, 3'b000};
        final_err         = frame_err;
        has_word          = (acc_cnt_reg != 3'd0) || pend_valid_reg;
        fin_data          = (acc_cnt_reg != 3'd0) ? acc_reg : pend_reg;
        fin_bytes         = (acc_cnt_reg != 3'd0) ? acc_cnt_reg : 3'd6;

        case (state_reg)
            ST_IDLE: begin
                if (gmii_rx_dv) begin
                    state_next = (gmii_rxd == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
                end
            end

            ST_PREAMBLE: begin
                if (gmii_rx_dv && gmii_rxd == SFD_BYTE) begin
                    state_next      = ST_DATA;
                    crc_next        = CRC32_INIT;
                    count_next      = '0;
                    acc_next        = '0;
                    acc_cnt_next    = '0;
                    pend_valid_next = 1'b0;
                    er_seen_next    = 1'b0;
                    ovf_next        = 1'b0;
                end else if (!(gmii_rx_dv && gmii_rxd == PREAMBLE_BYTE)) begin
                    state_next = ST_IDLE;
                end
            end

            ST_DATA: begin
                if (gmii_rx_dv) begin
                    crc_next = crc32_update(crc_reg, gmii_rxd);
                    if (count_reg != COUNT_MAX) begin
                        count_next = count_reg + 11'd1;
                    end
                    if (gmii_rx_er) begin
                        er_seen_next = 1'b1;
                    end
                    if (pend_valid_reg) begin
                        pend_valid_next = 1'b0;
                        if (normal_room) begin
                            wr_en_next    = 1'b1;
                            wr_entry_next = '{data: pend_reg, last: 1'b0, bytes: 3'd6, err: 1'b0};
                        end else begin
                            // Terminate the frame in the reserved slot so downstream never sees a dangling frame.
                            if (reserve_room) begin
                                wr_en_next    = 1'b1;
                                wr_entry_next = '{data: pend_reg, last: 1'b1, bytes: 3'd6, err: 1'b1};
                            end
                            ovf_next   = 1'b1;
                            state_next = ST_DROP;
                        end
                    end
                    if (acc_cnt_reg == 3'd5) begin
                        pend_next       = acc_reg | lane_byte;
                        pend_valid_next = 1'b1;
                        acc_next        = '0;
                        acc_cnt_next    = '0;
                    end else begin
                        acc_next     = acc_reg | lane_byte;
                        acc_cnt_next = acc_cnt_reg + 3'd1;
                    end
                end else begin
                    if (has_word) begin
                        if (!normal_room) begin
                            final_err = 1'b1;
                        end
                        if (reserve_room) begin
                            wr_en_next    = 1'b1;
                            wr_entry_next = '{data: fin_data, last: 1'b1, bytes: fin_bytes, err: final_err};
                        end
                    end
                    status_valid_next = 1'b1;
                    good_next         = !final_err;
                    if (final_err && drop_count_reg != 16'hFFFF) begin
                        drop_count_next = drop_count_reg + 16'd1;
                    end
                    pend_valid_next = 1'b0;
                    acc_cnt_next    = '0;
                    acc_next        = '0;
                    state_next      = ST_IDLE;
                end
            end

            ST_DROP: begin
                if (!gmii_rx_dv) begin
                    state_next = ST_IDLE;
                    if (ovf_reg) begin
                        status_valid_next = 1'b1;
                        good_next         = 1'b0;
                        ovf_next          = 1'b0;
                        if (drop_count_reg != 16'hFFFF) begin
                            drop_count_next = drop_count_reg + 16'd1;
                        end
                    end
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            crc_reg          <= CRC32_INIT;
            count_reg        <= '0;
            acc_reg          <= '0;
            acc_cnt_reg      <= '0;
            pend_reg         <= '0;
            pend_valid_reg   <= 1'b0;
            er_seen_reg      <= 1'b0;
            ovf_reg          <= 1'b0;
            wr_en_reg        <= 1'b0;
            wr_entry_reg     <= '0;
            status_valid_reg <= 1'b0;
            good_reg         <= 1'b0;
            drop_count_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            crc_reg          <= crc_next;
            count_reg        <= count_next;
            acc_reg          <= acc_next;
            acc_cnt_reg      <= acc_cnt_next;
            pend_reg         <= pend_next;
            pend_valid_reg   <= pend_valid_next;
            er_seen_reg      <= er_seen_next;
            ovf_reg          <= ovf_next;
            wr_en_reg        <= wr_en_next;
            wr_entry_reg     <= wr_entry_next;
            status_valid_reg <= status_valid_next;
            good_reg         <= good_next;
            drop_count_reg   <= drop_count_next;
        end
    end

    eth_rx_word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en_reg),
        .push_word (wr_entry_reg),
        .pop       (fifo_pop),
        .head_word (head_raw),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head     = rx_word_t'(head_raw);
    assign fifo_pop = mac_rx_valid && mac_rx_ready;

    // Gate the head entry so outputs read zero while the FIFO is empty.
    assign mac_rx_valid       = !fifo_empty;
    assign mac_rx_data        = mac_rx_valid ? head.data  : 48'd0;
    assign mac_rx_last        = mac_rx_valid ? head.last  : 1'b0;
    assign mac_rx_bytes       = mac_rx_valid ? head.bytes : 3'd0;
    assign mac_rx_err         = mac_rx_valid ? head.err   : 1'b0;
    assign frame_status_valid = status_valid_reg;
    assign frame_good         = good_reg;
    assign drop_count         = drop_count_reg;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Scoreboard bench for gmii_rx_framer: directed frames push expected words and
// status into queues; monitors pop and compare whatever the DUT presents.
module tb_gmii_rx_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [47:0] mac_rx_data;
    logic        mac_rx_valid;
    logic        mac_rx_ready;
    logic        mac_rx_last;
    logic [2:0]  mac_rx_bytes;
    logic        mac_rx_err;
    logic        frame_status_valid;
    logic        frame_good;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    gmii_rx_framer #(
        .FIFO_DEPTH(16),
        .MIN_FRAME (64)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .gmii_rxd          (gmii_rxd),
        .gmii_rx_dv        (gmii_rx_dv),
        .gmii_rx_er        (gmii_rx_er),
        .mac_rx_data       (mac_rx_data),
        .mac_rx_valid      (mac_rx_valid),
        .mac_rx_ready      (mac_rx_ready),
        .mac_rx_last       (mac_rx_last),
        .mac_rx_bytes      (mac_rx_bytes),
        .mac_rx_err        (mac_rx_err),
        .frame_status_valid(frame_status_valid),
        .frame_good        (frame_good),
        .drop_count        (drop_count)
    );

    typedef struct packed {
        logic [47:0] data;
        logic        last;
        logic [2:0]  bytes;
        logic        err;
    } exp_word_t;

    typedef struct packed {
        logic        good;
        logic [15:0] drops;
    } exp_status_t;

    exp_word_t   wq[$];
    exp_status_t sq[$];
    logic [7:0]  frm[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_drops = 16'd0;

    logic      hold_prev = 1'b0;
    exp_word_t snap;

    // Word, status and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_word_t   act;
        exp_word_t   exp;
        exp_status_t sact;
        exp_status_t sexp;
        if (rst_n) begin
            act = '{data: mac_rx_data, last: mac_rx_last, bytes: mac_rx_bytes, err: mac_rx_err};
            if (hold_prev) begin
                checks++;
                if (!mac_rx_valid || act !== snap) begin
                    failures++;
                    $display("FAIL stall_hold got valid=%0b word=%h required valid=1 word=%h", mac_rx_valid, act, snap);
                end
            end
            hold_prev = mac_rx_valid && !mac_rx_ready;
            snap      = act;
            if (mac_rx_valid && mac_rx_ready) begin
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL word_unexpected got data=%h last=%0b bytes=%0d err=%0b required none",
                             act.data, act.last, act.bytes, act.err);
                end else begin
                    exp = wq.pop_front();
                    if (act !== exp) begin
                        failures++;
                        $display("FAIL word got data=%h last=%0b bytes=%0d err=%0b required data=%h last=%0b bytes=%0d err=%0b",
                                 act.data, act.last, act.bytes, act.err, exp.data, exp.last, exp.bytes, exp.err);
                    end else begin
                        $display("word data=%h last=%0b bytes=%0d err=%0b ok", act.data, act.last, act.bytes, act.err);
                    end
                end
            end
            if (frame_status_valid) begin
                sact = '{good: frame_good, drops: drop_count};
                checks++;
                if (sq.size() == 0) begin
                    failures++;
                    $display("FAIL status_unexpected got good=%0b drops=%0d required none", sact.good, sact.drops);
                end else begin
                    sexp = sq.pop_front();
                    if (sact !== sexp) begin
                        failures++;
                        $display("FAIL status got good=%0b drops=%0d required good=%0b drops=%0d",
                                 sact.good, sact.drops, sexp.good, sexp.drops);
                    end else begin
                        $display("status good=%0b drops=%0d ok", sact.good, sact.drops);
                    end
                end
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic build_frame(input int n, input int mult, input int seed);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < n; i++) begin
            frm.push_back(8'(i * mult + seed));
        end
        fcs = fcs_of(frm);
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
    endtask

    // Push the expected words for the whole of frm; err goes on the last word only.
    task automatic expect_frame(input logic err);
        int          n;
        int          nb;
        logic [47:0] d;
        logic        lst;
        n = frm.size();
        for (int w = 0; w * 6 < n; w++) begin
            d  = '0;
            nb = n - w * 6;
            if (nb > 6) nb = 6;
            for (int k = 0; k < nb; k++) begin
                d[47-8*k -: 8] = frm[w*6+k];
            end
            lst = (w * 6 + nb == n);
            wq.push_back('{data: d, last: lst, bytes: 3'(nb), err: lst ? err : 1'b0});
        end
    endtask

    task automatic send(input logic [7:0] b, input logic e);
        @(posedge clk);
        #1;
        gmii_rxd   = b;
        gmii_rx_dv = 1'b1;
        gmii_rx_er = e;
    endtask

    task automatic drive_frame(input int er_idx, input int rst_idx, input int rst_len);
        for (int i = 0; i < 7; i++) send(8'h55, 1'b0);
        send(8'hD5, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            send(frm[i], i == er_idx);
            if (i == rst_idx) rst_n = 1'b0;
            if (rst_idx >= 0 && i == rst_idx + rst_len) rst_n = 1'b1;
        end
        @(posedge clk);
        #1;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (12) @(posedge clk);
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while ((wq.size() != 0 || sq.size() != 0) && c < 500) begin
            @(posedge clk);
            c++;
        end
        checks++;
        if (wq.size() != 0 || sq.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got words_left=%0d status_left=%0d required 0", name, wq.size(), sq.size());
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout required finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        gmii_rxd     = 8'h00;
        gmii_rx_dv   = 1'b0;
        gmii_rx_er   = 1'b0;
        mac_rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(mac_rx_valid), 64'd0);
        check("rst_data", 64'(mac_rx_data), 64'd0);
        check("rst_last", 64'(mac_rx_last), 64'd0);
        check("rst_bytes", 64'(mac_rx_bytes), 64'd0);
        check("rst_err", 64'(mac_rx_err), 64'd0);
        check("rst_status", 64'(frame_status_valid), 64'd0);
        check("rst_good", 64'(frame_good), 64'd0);
        check("rst_drops", 64'(drop_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        mac_rx_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Good 64-byte frame: 10 full words plus a 4-byte last word.
        build_frame(60, 3, 1);
        expect_frame(1'b0);
        sq.push_back('{good: 1'b1, drops: exp_drops});
        drive_frame(-1, -1, 0);
        wait_drain("good");

        // Same frame with one payload bit flipped after FCS was computed.
        build_frame(60, 3, 1);
        frm[20] = frm[20] ^ 8'h01;
        expect_frame(1'b1);
        exp_drops++;
        sq.push_back('{good: 1'b0, drops: exp_drops});
        drive_frame(-1, -1, 0);
        wait_drain("badfcs");

        // 60-byte runt with correct FCS: exactly 10 words, last one full.
        build_frame(56, 5, 2);
        expect_frame(1'b1);
        exp_drops++;
        sq.push_back('{good: 1'b0, drops: exp_drops});
        drive_frame(-1, -1, 0);
        wait_drain("runt");

        // PHY error on byte 30 of an otherwise good frame.
        build_frame(60, 3, 1);
        expect_frame(1'b1);
        exp_drops++;
        sq.push_back('{good: 1'b0, drops: exp_drops});
        drive_frame(30, -1, 0);
        wait_drain("rxer");

        // 200-byte frame into a stalled consumer: 15 words plus a terminating error word.
        mac_rx_ready = 1'b0;
        build_frame(196, 7, 9);
        for (int w = 0; w < 16; w++) begin
            logic [47:0] d;
            d = '0;
            for (int k = 0; k < 6; k++) begin
                d[47-8*k -: 8] = frm[w*6+k];
            end
            wq.push_back('{data: d, last: (w == 15), bytes: 3'd6, err: (w == 15)});
        end
        exp_drops++;
        sq.push_back('{good: 1'b0, drops: exp_drops});
        drive_frame(-1, -1, 0);
        @(negedge clk);
        check("ovf_valid_stalled", 64'(mac_rx_valid), 64'd1);
        @(posedge clk);
        #1;
        mac_rx_ready = 1'b1;
        wait_drain("overflow");
        @(negedge clk);
        check("ovf_no_extra", 64'(mac_rx_valid), 64'd0);

        // Reset in the middle of a stalled frame flushes everything.
        @(posedge clk);
        #1;
        mac_rx_ready = 1'b0;
        build_frame(60, 1, 0);
        drive_frame(-1, 40, 4);
        exp_drops = 16'd0;
        @(negedge clk);
        check("post_rst_valid", 64'(mac_rx_valid), 64'd0);
        check("post_rst_drops", 64'(drop_count), 64'd0);
        @(posedge clk);
        #1;
        mac_rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_rst_flushed", 64'(mac_rx_valid), 64'd0);

        build_frame(60, 11, 4);
        expect_frame(1'b0);
        sq.push_back('{good: 1'b1, drops: exp_drops});
        drive_frame(-1, -1, 0);
        wait_drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
